// File: rtl/spram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM (1-cycle registered read).
// Optional macro SPRAM_ARB_RR_EN selects round-robin on contested cycles; default is fixed A priority.
module spram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_we,
    output logic                  ram_re
);

    logic last_b_q, last_b_d;
    logic rd_a_q, rd_a_d;
    logic rd_b_q, rd_b_d;
    logic contested, grant_a, grant_b;

    always_comb begin
        contested = a_req && b_req;
`ifdef SPRAM_ARB_RR_EN
        grant_a = a_req && (!b_req || last_b_q);
`else
        grant_a = a_req;
`endif
        grant_b = b_req && !grant_a;
        // Reset suppresses every grant so no RAM access can start while rst is high.
        if (rst) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end

        a_ack    = grant_a;
        b_ack    = grant_b;
        ram_addr = a_addr;
        ram_din  = a_wdata;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        if (grant_a) begin
            ram_we = a_we;
            ram_re = !a_we;
        end else if (grant_b) begin
            ram_addr = b_addr;
            ram_din  = b_wdata;
            ram_we   = b_we;
            ram_re   = !b_we;
        end

        last_b_d = last_b_q;
        if (contested) begin
            last_b_d = grant_b;
        end
        rd_a_d = grant_a && !a_we;
        rd_b_d = grant_b && !b_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
            rd_a_q   <= 1'b0;
            rd_b_q   <= 1'b0;
        end else begin
            last_b_q <= last_b_d;
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
        end
    end

    assign a_rvalid = rd_a_q;
    assign b_rvalid = rd_b_q;
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: RAM environment, transaction-level reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_spram_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ack, a_rvalid, b_ack, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_we, ram_re;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_we(ram_we), .ram_re(ram_re)
    );

    // RAM the arbiter drives
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = (i == 5) ? 16'h1234 : '0;
        ram_dout = '0;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] <= ram_din;
            if (ram_re) ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who is served, what RAM sees, which read returns what
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    initial begin
        logic ea, eb, pa, pb, m_last_b;
        logic [DW-1:0] pd;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = (i == 5) ? 16'h1234 : '0;
        pa = 1'b0; pb = 1'b0; pd = '0; m_last_b = 1'b1;
        forever begin
            @(negedge clk);
`ifdef SPRAM_ARB_RR_EN
            ea = !rst && a_req && (!b_req || m_last_b);
`else
            ea = !rst && a_req;
`endif
            eb = !rst && b_req && !ea;
            chk("a_ack", {31'd0, a_ack}, {31'd0, ea});
            chk("b_ack", {31'd0, b_ack}, {31'd0, eb});
            chk("ram_we", {31'd0, ram_we}, {31'd0, (ea && a_we) || (eb && b_we)});
            chk("ram_re", {31'd0, ram_re}, {31'd0, (ea && !a_we) || (eb && !b_we)});
            chk("ram_addr", {22'd0, ram_addr}, {22'd0, eb ? b_addr : a_addr});
            if (ea || eb) chk("ram_din", {16'd0, ram_din}, {16'd0, eb ? b_wdata : a_wdata});
            chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, pa && !rst});
            chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, pb && !rst});
            if (pa && !rst) chk("a_rdata", {16'd0, a_rdata}, {16'd0, pd});
            if (pb && !rst) chk("b_rdata", {16'd0, b_rdata}, {16'd0, pd});
            if (rst) begin
                pa = 1'b0; pb = 1'b0; m_last_b = 1'b1;
            end else begin
                pa = ea && !a_we;
                pb = eb && !b_we;
                if (pa) pd = ref_mem[a_addr];
                if (pb) pd = ref_mem[b_addr];
                if (ea && a_we) ref_mem[a_addr] = a_wdata;
                if (eb && b_we) ref_mem[b_addr] = b_wdata;
                if (a_req && b_req) m_last_b = eb;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    initial begin
        // Reset: requests are ignored while rst is high
        a_req = 1'b1; a_addr = 10'h005;
        neg;
        chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
        chk("rst_ram_re", {31'd0, ram_re}, 32'd0);
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        tick; rst = 1'b0; a_req = 1'b0;
        tick;

        // A reads 0x005
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005;
        neg;
        chk("t1_a_ack", {31'd0, a_ack}, 32'd1);
        chk("t1_ram_re", {31'd0, ram_re}, 32'd1);
        tick; a_req = 1'b0;
        neg;
        chk("t1_a_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("t1_a_rdata", {16'd0, a_rdata}, 32'h1234);
        chk("t1_b_rvalid", {31'd0, b_rvalid}, 32'd0);

        // B writes 0xBEEF to 0x3FF then reads it back
        tick; b_req = 1'b1; b_we = 1'b1; b_addr = 10'h3FF; b_wdata = 16'hBEEF;
        neg;
        chk("t2_b_ack_w", {31'd0, b_ack}, 32'd1);
        chk("t2_ram_we", {31'd0, ram_we}, 32'd1);
        tick; b_we = 1'b0;
        neg;
        chk("t2_b_ack_r", {31'd0, b_ack}, 32'd1);
        tick; b_req = 1'b0;
        neg;
        chk("t2_b_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("t2_b_rdata", {16'd0, b_rdata}, 32'hBEEF);

        // Continuous contention for 4 cycles
        tick; a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005;
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'h3FF;
        for (int k = 0; k < 4; k++) begin
            neg;
`ifdef SPRAM_ARB_RR_EN
            chk("t3_a_ack", {31'd0, a_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_b_ack", {31'd0, b_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
`else
            chk("t3_a_ack", {31'd0, a_ack}, 32'd1);
            chk("t3_b_ack", {31'd0, b_ack}, 32'd0);
`endif
            tick;
        end
        a_req = 1'b0;
        neg;
        chk("t3_b_alone", {31'd0, b_ack}, 32'd1);
        tick; b_req = 1'b0;
        neg;
        chk("t3_b_rdata", {16'd0, b_rdata}, 32'hBEEF);

        // Reset the cycle after an acked A read
        tick; a_req = 1'b1; a_addr = 10'h005;
        neg;
        tick; a_req = 1'b0; rst = 1'b1;
        neg;
        chk("t4_rvalid_rst", {31'd0, a_rvalid}, 32'd0);
        tick; rst = 1'b0;
        neg;
        chk("t4_rvalid_post", {31'd0, a_rvalid}, 32'd0);
        tick; a_req = 1'b1; a_addr = 10'h020; b_req = 1'b1; b_we = 1'b0; b_addr = 10'h020;
        neg;
        chk("t4_first_a", {31'd0, a_ack}, 32'd1);
        chk("t4_first_b", {31'd0, b_ack}, 32'd0);
        tick; a_req = 1'b0;
        neg;
        chk("t4_b_next", {31'd0, b_ack}, 32'd1);

        // A read vs B write to 0x010, contested after A won the last contest
        tick; a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010;
        b_req = 1'b1; b_we = 1'b1; b_addr = 10'h010; b_wdata = 16'h00AA;
        neg;
`ifdef SPRAM_ARB_RR_EN
        chk("t5_b_first", {31'd0, b_ack}, 32'd1);
        tick; b_req = 1'b0;
        neg;
        chk("t5_a_next", {31'd0, a_ack}, 32'd1);
        tick; a_req = 1'b0;
        neg;
        chk("t5_a_rdata", {16'd0, a_rdata}, 32'h00AA);
`else
        chk("t5_a_first", {31'd0, a_ack}, 32'd1);
        tick; a_req = 1'b0;
        neg;
        chk("t5_b_next", {31'd0, b_ack}, 32'd1);
        chk("t5_a_old", {16'd0, a_rdata}, 32'h0000);
        tick; b_req = 1'b0;
        neg;
`endif
        tick; a_req = 1'b1; a_addr = 10'h010;
        neg;
        tick; a_req = 1'b0;
        neg;
        chk("t5_readback", {16'd0, a_rdata}, 32'h00AA);

        tick; tick; tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-port arbiter that shares one single-port synchronous RAM (1-cycle registered read, separate write and read enables) between two requesters, e.g. the CPU data port (A) and a DMA/debug port (B). It grants at most one access per clock, drives the RAM control/address/data lines, and returns read data to the winner with a registered valid strobe. It sits directly in front of the RAM instance; requesters never touch the RAM pins.

## Interface
- ADDR_WIDTH, 10, RAM word-address width
- DATA_WIDTH, 16, RAM data width

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- a_req  in  1  port A access request (held until a_ack)
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  ADDR_WIDTH  port A word address
- a_wdata  in  DATA_WIDTH  port A write data
- a_ack  out  1  port A granted this cycle (combinational)
- a_rvalid  out  1  port A read data valid (registered)
- a_rdata  out  DATA_WIDTH  port A read data
- b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata  same as port A, for port B
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM registered read data
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable

## Operation
- Handshake: a transfer completes at the rising edge where x_req && x_ack. Requester holds x_we/x_addr/x_wdata stable while x_req is high and not acked; may deassert req or present a new request the cycle after ack (back-to-back allowed).
- Grant is combinational from current req inputs and state register last_b (1 = B won last contested cycle).
- Only one requesting: that port wins.
- Both requesting: winner per Configuration. Loser sees x_ack=0 and retries next cycle.
- Winner's fields drive RAM: ram_addr=x_addr, ram_din=x_wdata, ram_we=x_we, ram_re=~x_we.
- No grant: ram_we=0, ram_re=0, ram_addr=a_addr, ram_din=a_wdata.
- Read tracking: registers rd_a, rd_b set on the edge completing a read by A/B, else cleared. a_rvalid=rd_a, b_rvalid=rd_b.
- a_rdata=b_rdata=ram_dout (shared wire); meaningful only when matching rvalid is high.
- last_b updates only on contested cycles (both req high): last_b <= (winner==B).
- Writes produce no rvalid. Read-after-write to same address by either port on consecutive cycles returns new data (RAM write completes before next read edge).

## Timing
- Grant/ack: 0 cycles (same cycle as req if won).
- Read latency: rvalid high exactly 1 cycle after the acked read edge, for one cycle per read; pipelined reads give consecutive rvalids.
- Max wait for a requester under continuous contention: 1 cycle (round-robin build); unbounded for B (fixed-priority build).
- Reset (async, immediate): a_rvalid=b_rvalid=0, last_b=1 (A wins first contest). Combinational outputs follow inputs during reset but ram_we=ram_re=0 and a_ack=b_ack=0 forced while rst high.
- Reset mid-read: pending rvalid is dropped; the read is lost and requester must reissue.
- Simultaneous A read and B write: one served per cycle, never both; no RAM port ever sees we and re together.

## Configuration
- SPRAM_ARB_RR_EN defined: contested cycles use round-robin; winner is A if last_b=1, else B.
- SPRAM_ARB_RR_EN undefined: fixed priority, A always wins contests; last_b register still exists and updates but does not affect grant.

## Test plan
- Reset then A reads addr 0x005 holding 0x1234 -> a_ack same cycle, ram_re=1, a_rvalid=1 with a_rdata=0x1234 next cycle, b_rvalid=0.
- B writes 0xBEEF to 0x3FF, then B reads 0x3FF next cycle -> b_ack both cycles, b_rvalid next-next cycle with 0xBEEF.
- RR build, A and B both hold read req for 4 cycles -> grants A,B,A,B; rvalids alternate one cycle later; no cycle with both acks.
- Fixed build, both continuously request -> a_ack every cycle, b_ack never; drop a_req -> b_ack that cycle.
- Assert rst the cycle after A's acked read -> a_rvalid low immediately, stays low after release; first contest after reset goes to A.
- A read 0x010 and B write 0x010=0x00AA contested, RR with last_b=0 -> B writes first, A reads next cycle and gets 0x00AA.
